fifo_rd_burst_ctrl: RTL and testbench

FIFO_RD_BURST_CTRL -- requirements
Module: fifo_rd_burst_ctrl

---
 rtl/fifo_ctrl_pkg.sv | 17 +
 rtl/axis_skid_buf.sv | 60 ++++++
 rtl/fifo_rd_burst_ctrl.sv | 138 +++++++++++++
 tb/tb_fifo_rd_burst_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO read-side burst controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_PTR_WIDTH  = 3;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BURST_LEN  = 4;
  localparam int DEF_TIMEOUT    = 16;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry output buffer; entry 0 is the head presented on out_*.
// Latency: a word written with in_vld is visible on out_vld the next cycle.
// Backpressure: no in_rdy; the writer must keep (count + in-flight - pop) <= 2.
// Ports: clk/rst (sync, active high), in_vld/in_dat write side,
//        out_vld/out_dat/out_rdy read side, count = stored words (0..2).
module axis_skid_buf #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  input  logic             out_rdy,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] ent0_q, ent0_d;
  logic [WIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       cnt_pop;
  logic             pop;

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    pop     = (cnt_q != 2'd0) && out_rdy;
    cnt_pop = cnt_q - {1'b0, pop};
    // Pop shifts entry 1 forward; a write then lands in the first free slot.
    if (pop) begin
      ent0_d = ent1_q;
    end
    if (in_vld) begin
      if (cnt_pop == 2'd0) begin
        ent0_d = in_dat;
      end else begin
        ent1_d = in_dat;
      end
    end
    cnt_d = cnt_pop + {1'b0, in_vld};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_vld = (cnt_q != 2'd0);
  assign out_dat = ent0_q;
  assign count   = cnt_q;

endmodule

// File: rtl/fifo_rd_burst_ctrl.sv
// Reads bursts from a FIFO read port and emits them on an AXI-Stream master with tlast per burst.
// Latency: fifo_rd -> rdata next cycle -> captured into buffer -> tvalid; 1 beat/cycle sustained.
// Backpressure: tready stalls hold the buffer; reads are throttled to keep <= 2 words outstanding.
// Ports: rclk/rrst (sync, active high), enable gates burst starts,
//        fifo_empty/fifo_usedw/fifo_rdata/fifo_rd FIFO read side,
//        m_axis_tdata/tvalid/tready/tlast stream side, busy = not IDLE.
module fifo_rd_burst_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int PTR_WIDTH  = DEF_PTR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [PTR_WIDTH:0]    fifo_usedw,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy
);

  localparam int CNT_W = PTR_WIDTH + 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);
  localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rd_rem_q, rd_rem_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             inflight_q, inflight_d;
  logic             inflight_last_q, inflight_last_d;

  logic             start_full, start_part, last_rd, beat_acc;
  logic [1:0]       buf_cnt;
  logic [2:0]       occ;
  logic             buf_vld;
  logic [DATA_WIDTH:0] buf_dat;

  always_comb begin
    start_full = enable && (fifo_usedw >= BURST_LEN_C);
    // A zero usedw alongside a stale non-empty flag would start a burst that never ends.
    start_part = enable && !fifo_empty && (fifo_usedw != '0) &&
                 (fifo_usedw < BURST_LEN_C) && (timer_q == TMR_LAST);
    last_rd    = fifo_rd && (rd_rem_q == CNT_W'(1));
    beat_acc   = buf_vld && m_axis_tready;
    // Words held after this edge, before any new read; the popped beat frees its slot now.
    occ        = {1'b0, buf_cnt} + {2'b0, inflight_q} - {2'b0, beat_acc};
  end

  // State register
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_full || start_part) state_d = ST_BURST;
      ST_BURST: if (last_rd) state_d = ST_DRAIN;
      ST_DRAIN: if (beat_acc && m_axis_tlast) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    fifo_rd = (state_q == ST_BURST) && !fifo_empty && (rd_rem_q != '0) && (occ < 3'd2);
    busy    = (state_q != ST_IDLE);
  end

  // Counters and read pipeline
  always_comb begin
    rd_rem_d = rd_rem_q;
    if (state_q == ST_IDLE) begin
      if (start_full) begin
        rd_rem_d = BURST_LEN_C;
      end else if (start_part) begin
        rd_rem_d = fifo_usedw;
      end
    end else if (fifo_rd) begin
      rd_rem_d = rd_rem_q - CNT_W'(1);
    end

    // Saturates at the last value so a lagging usedw of 0 does not wrap the timer.
    timer_d = '0;
    if ((state_q == ST_IDLE) && !start_full && !start_part && !fifo_empty && enable) begin
      timer_d = (timer_q == TMR_LAST) ? timer_q : timer_q + TMR_W'(1);
    end

    inflight_d      = fifo_rd;
    inflight_last_d = last_rd;
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rd_rem_q        <= '0;
      timer_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      rd_rem_q        <= rd_rem_d;
      timer_q         <= timer_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  // tlast travels with its word so partial bursts need no separate beat counter.
  axis_skid_buf #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk    (rclk),
    .rst    (rrst),
    .in_vld (inflight_q),
    .in_dat ({inflight_last_q, fifo_rdata}),
    .out_vld(buf_vld),
    .out_dat(buf_dat),
    .out_rdy(m_axis_tready),
    .count  (buf_cnt)
  );

  assign m_axis_tvalid = buf_vld;
  assign m_axis_tdata  = buf_dat[DATA_WIDTH-1:0];
  assign m_axis_tlast  = buf_vld && buf_dat[DATA_WIDTH];

endmodule

// File: tb/tb_fifo_rd_burst_ctrl.sv
// Bench for fifo_rd_burst_ctrl: FIFO model, scoreboard of expected beats, vector table plus corner sequences.
// Latency: n/a.
// Backpressure: tready driven from per-vector 4-cycle patterns.
module tb_fifo_rd_burst_ctrl;

  localparam int PW = 3;
  localparam int DW = 32;
  localparam int BL = 4;
  localparam int TO = 16;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty;
  logic [PW:0]   fifo_usedw;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_rd;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready = 1'b0;
  logic          tlast;
  logic          busy;

  logic          empty_q = 1'b1;
  logic          force_empty = 1'b0;
  logic [PW:0]   usedw_q = '0;

  logic [DW-1:0] mem[$];
  logic [DW:0]   exp_q[$];

  int            checks = 0;
  int            failures = 0;
  int            cyc_n = 0;
  int            beats = 0;
  int            out_cnt = 0;
  int            idle_cnt = 0;
  bit            seen_busy = 0;
  bit            prev_stall = 0;
  logic [DW:0]   prev_beat = '0;
  logic [DW:0]   mon_e;
  int            rd_cyc[$];

  always #5 rclk = ~rclk;

  assign fifo_empty = empty_q | force_empty;
  assign fifo_usedw = usedw_q;

  fifo_rd_burst_ctrl #(
    .PTR_WIDTH (PW),
    .DATA_WIDTH(DW),
    .BURST_LEN (BL),
    .TIMEOUT   (TO)
  ) dut (
    .rclk         (rclk),
    .rrst         (rrst),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_usedw   (fifo_usedw),
    .fifo_rdata   (fifo_rdata),
    .fifo_rd      (fifo_rd),
    .m_axis_tdata (tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tlast (tlast),
    .busy         (busy)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // FIFO model: read data one cycle after fifo_rd, registered flags.
  always @(posedge rclk) begin
    if (fifo_rd === 1'b1 && mem.size() > 0) begin
      fifo_rdata <= mem.pop_front();
    end
    empty_q <= (mem.size() == 0);
    usedw_q <= (PW+1)'(mem.size());
  end

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge rclk) begin
    cyc_n++;
    if (rrst) begin
      beats = 0;
      out_cnt = 0;
      idle_cnt = 0;
      seen_busy = 0;
      prev_stall = 0;
      rd_cyc.delete();
    end else begin
      if (prev_stall) begin
        chk("hold_valid", tvalid, 1);
        chk("hold_payload", {tlast, tdata}, prev_beat);
      end
      if (fifo_rd) begin
        rd_cyc.push_back(cyc_n);
        chk("rd_while_empty", fifo_empty, 0);
        out_cnt++;
      end
      if (busy) seen_busy = 1;
      else if (!seen_busy && enable && !fifo_empty) idle_cnt++;
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got data %0h last %0d, expected no beat", tdata, tlast);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_data", tdata, mon_e[DW-1:0]);
          chk("beat_last", tlast, mon_e[DW]);
        end
        beats++;
        out_cnt--;
      end
      chk("outstanding_le2", (out_cnt > 2), 0);
      prev_stall = tvalid && !tready;
      prev_beat = {tlast, tdata};
    end
  end

  task automatic cyc();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    enable = 1'b0;
    tready = 1'b0;
    force_empty = 1'b0;
    cyc();
    cyc();
    mem.delete();
    exp_q.delete();
    cyc();
    rrst = 1'b0;
  endtask

  typedef struct {
    int       n_words;
    logic [3:0] rdy_pat;
    int       exp_beats;
    int       exp_idle;
    int       exp_span;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [DW-1:0] w;
    logic          lb;
    logic [3:0]    pat;

    vecs[0] = '{4, 4'b1111, 4, 1, 3};
    vecs[1] = '{2, 4'b1111, 2, 16, -1};
    vecs[2] = '{4, 4'b0101, 4, 1, -1};
    vecs[3] = '{8, 4'b1111, 8, 1, 3};
    vecs[4] = '{6, 4'b0110, 6, 1, -1};
    vecs[5] = '{1, 4'b1111, 1, 16, -1};
    vecs[6] = '{5, 4'b1001, 5, 1, -1};

    // Reset state
    do_reset();
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_busy", busy, 0);

    // Table-driven bursts
    for (int r = 0; r < 7; r++) begin
      do_reset();
      pat = vecs[r].rdy_pat;
      enable = 1'b1;
      for (int i = 0; i < vecs[r].n_words; i++) begin
        w = $urandom;
        lb = ((i % BL) == BL - 1) || (i == vecs[r].n_words - 1);
        mem.push_back(w);
        exp_q.push_back({lb, w});
      end
      for (int k = 0; k < 200; k++) begin
        tready = pat[k % 4];
        cyc();
        if (k > 4 && beats >= vecs[r].exp_beats && !busy) break;
      end
      tready = 1'b1;
      repeat (4) cyc();
      chk("vec_beats", beats, vecs[r].exp_beats);
      chk("vec_sb_left", exp_q.size(), 0);
      chk("vec_busy_end", busy, 0);
      chk("vec_idle_cycles", idle_cnt, vecs[r].exp_idle);
      if (vecs[r].exp_span >= 0) begin
        if (rd_cyc.size() >= 4) chk("vec_rd_span", rd_cyc[3] - rd_cyc[0], vecs[r].exp_span);
        else chk("vec_rd_count", rd_cyc.size(), 4);
      end
    end

    // Enable dropped after the first beat: burst completes, no restart.
    do_reset();
    enable = 1'b1;
    tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      mem.push_back(w);
      if (i < 4) exp_q.push_back({(i == 3) ? 1'b1 : 1'b0, w});
    end
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (beats >= 1) break;
    end
    enable = 1'b0;
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (beats >= 4 && !busy) break;
    end
    repeat (20) cyc();
    chk("en_drop_beats", beats, 4);
    chk("en_drop_busy", busy, 0);
    chk("en_drop_reads", rd_cyc.size(), 4);
    chk("en_drop_usedw", fifo_usedw, 4);
    chk("en_drop_sb_left", exp_q.size(), 0);

    // Reset with two words buffered under backpressure.
    do_reset();
    enable = 1'b1;
    tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      mem.push_back(w);
    end
    repeat (8) cyc();
    chk("pre_rst_tvalid", tvalid, 1);
    chk("pre_rst_reads", rd_cyc.size(), 2);
    rrst = 1'b1;
    enable = 1'b0;
    cyc();
    chk("post_rst_tvalid", tvalid, 0);
    chk("post_rst_fifo_rd", fifo_rd, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_tdata", tdata, 0);
    rrst = 1'b0;
    tready = 1'b1;
    repeat (5) cyc();
    chk("post_rst_beats", beats, 0);

    // fifo_empty forced for three cycles after the first read.
    do_reset();
    enable = 1'b1;
    tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      mem.push_back(w);
      exp_q.push_back({(i == 3) ? 1'b1 : 1'b0, w});
    end
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (rd_cyc.size() >= 1) break;
    end
    force_empty = 1'b1;
    repeat (3) cyc();
    force_empty = 1'b0;
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (beats >= 4 && !busy) break;
    end
    chk("pause_beats", beats, 4);
    chk("pause_busy", busy, 0);
    chk("pause_sb_left", exp_q.size(), 0);
    if (rd_cyc.size() == 4) begin
      chk("pause_gap", rd_cyc[1] - rd_cyc[0], 4);
      chk("pause_span", rd_cyc[3] - rd_cyc[0], 6);
    end else begin
      chk("pause_rd_count", rd_cyc.size(), 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
